// File: rtl/pipe_reg_packer_if.sv
// ============================================================================
// Module      : pipe_reg_packer_if
// Description : Upstream/downstream handshake and field bus for pipe_reg_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_reg_packer_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_inst;
    logic [31:0]  in_a_data;
    logic [31:0]  in_b_data;
    logic [31:0]  in_pc;
    logic [2:0]   in_jump;
    logic         in_alu_a_src;
    logic [3:0]   in_alu_b_src;
    logic [15:0]  in_aluop;
    logic [4:0]   in_mem_wen_pick;
    logic [1:0]   in_reg_valid;
    logic         in_mem_read;
    logic         in_reg_write;
    logic [15:0]  in_reg_write_src;
    logic [5:0]   in_reg_write_tgt;
    logic [3:0]   in_mul_control;
    logic [7:0]   in_branch;
    logic         in_r_type;
    logic [4:0]   in_regfile_waddr;
    logic         out_valid;
    logic         out_ready;
    logic [219:0] out_data;

    // Producer of decoded fields and consumer of the packed bundle
    modport master (
        output in_valid, in_inst, in_a_data, in_b_data, in_pc, in_jump,
               in_alu_a_src, in_alu_b_src, in_aluop, in_mem_wen_pick,
               in_reg_valid, in_mem_read, in_reg_write, in_reg_write_src,
               in_reg_write_tgt, in_mul_control, in_branch, in_r_type,
               in_regfile_waddr, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_inst, in_a_data, in_b_data, in_pc, in_jump,
               in_alu_a_src, in_alu_b_src, in_aluop, in_mem_wen_pick,
               in_reg_valid, in_mem_read, in_reg_write, in_reg_write_src,
               in_reg_write_tgt, in_mul_control, in_branch, in_r_type,
               in_regfile_waddr, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_packer.sv
// ============================================================================
// Module      : pipe_reg_packer
// Description : Packs decoded fields into the 220-bit pipe-register bundle and
//               holds it in a valid/ready stage. Define PIPE_REG_SKID_EN for
//               the two-entry build with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_packer #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_reg_packer_if.slave       bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = {STALL_CNT_W{1'b1}};

`ifdef PIPE_REG_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1,
        S_FULL2 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [219:0]           main_q, main_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [219:0]           w_packed;
    logic                   w_out_valid;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;
`ifdef PIPE_REG_SKID_EN
    logic [219:0]           skid_q, skid_d;
    logic                   in_ready_q, in_ready_d;
`endif

    assign w_packed = {19'd0,
                       bus.in_inst, bus.in_a_data, bus.in_b_data, bus.in_pc,
                       bus.in_jump, bus.in_alu_a_src, bus.in_alu_b_src,
                       bus.in_aluop, bus.in_mem_wen_pick, bus.in_reg_valid,
                       bus.in_mem_read, bus.in_reg_write, bus.in_reg_write_src,
                       bus.in_reg_write_tgt, bus.in_mul_control, bus.in_branch,
                       bus.in_r_type, bus.in_regfile_waddr};

    assign w_out_valid = (state_q != S_EMPTY);

    // Held low while rst is asserted so nothing is accepted in the reset cycle
`ifdef PIPE_REG_SKID_EN
    assign w_in_ready = in_ready_q & ~rst;
`else
    assign w_in_ready = (~w_out_valid | bus.out_ready) & ~rst;
`endif

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_REG_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            S_EMPTY: begin
                if (w_in_fire) begin
                    state_d = S_FULL1;
                    main_d  = w_packed;
                end
            end
            S_FULL1: begin
`ifdef PIPE_REG_SKID_EN
                if (w_in_fire && w_out_fire) begin
                    main_d = w_packed;
                end else if (w_in_fire) begin
                    state_d = S_FULL2;
                    skid_d  = w_packed;
                end else if (w_out_fire) begin
                    state_d = S_EMPTY;
                end
`else
                // A fire here implies out_ready, so the held beat leaves as the new one lands
                if (w_in_fire) begin
                    main_d = w_packed;
                end else if (w_out_fire) begin
                    state_d = S_EMPTY;
                end
`endif
            end
`ifdef PIPE_REG_SKID_EN
            S_FULL2: begin
                if (w_out_fire) begin
                    state_d = S_FULL1;
                    main_d  = skid_q;
                end
            end
`endif
            default: state_d = S_EMPTY;
        endcase

        // Redirect drops held entries; payload registers stay as they were
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
`ifdef PIPE_REG_SKID_EN
            skid_d  = skid_q;
`endif
        end
    end

`ifdef PIPE_REG_SKID_EN
    assign in_ready_d = (state_d != S_FULL2);
`endif

    always_comb begin
        stall_d = stall_q;
        if (w_out_valid && !bus.out_ready && (stall_q != c_STALL_MAX)) begin
            stall_d = stall_q + c_STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            stall_q    <= '0;
`ifdef PIPE_REG_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            stall_q    <= stall_d;
`ifdef PIPE_REG_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = main_q;
    assign stall_cnt     = stall_q;

endmodule

`default_nettype wire

// File: doc/pipe_reg_packer.md
# pipe_reg_packer

Packs decoded-instruction fields into the 220-bit pipe-register bundle and holds it in a valid/ready pipeline stage. It sits at the decode-to-execute boundary and produces the `datain` bundle consumed by the downstream field unpacker. Backpressure from the AXI-SRAM-stalled execute stage is absorbed by an optional skid entry, so `in_ready` is registered.

## Interface
- `STALL_CNT_W`, 32, width of the saturating stall counter
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: drop all held entries (branch/exception redirect)
- `in_valid` in 1 / `in_ready` out 1: upstream handshake
- `in_inst`, `in_a_data`, `in_b_data`, `in_pc` in 32 each: instruction, operand A, operand B, PC
- `in_jump` in 3: {jump_short, jump_long, jump_alu}
- `in_alu_a_src` in 1; `in_alu_b_src` in 4; `in_aluop` in 16
- `in_mem_wen_pick` in 5; `in_reg_valid` in 2: {reg_a_valid, reg_b_valid}
- `in_mem_read` in 1; `in_reg_write` in 1
- `in_reg_write_src` in 16; `in_reg_write_tgt` in 6; `in_mul_control` in 4
- `in_branch` in 8: {beq, bgez, blez, bltz, bne, bgtz, bgezal, bltzal}
- `in_r_type` in 1; `in_regfile_waddr` in 5
- `out_valid` out 1 / `out_ready` in 1: downstream handshake
- `out_data` out 220: packed bundle
- `stall_cnt` out STALL_CNT_W: cycles with `out_valid & !out_ready`, saturating

## Operation
- Bundle layout (MSB→LSB):
  - [219:201] = 0
  - inst [200:169], A [168:137], B [136:105], PC [104:73]
  - jump_short 72, jump_long 71, jump_alu 70, alu_a_src 69
  - alu_b_src [68:65], aluop [64:49], mem_wen_pick [48:44]
  - reg_a_valid 43, reg_b_valid 42, mem_read 41, reg_write 40
  - reg_write_src [39:24], reg_write_tgt [23:18], mul_control [17:14]
  - beq 13 … bltzal 6 (in `in_branch` order), r_type 5, regfile_waddr [4:0]
- Packing is combinational; the packed word is captured into the main entry or the skid entry.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States (skid build):
  - EMPTY:
    - in_fire → FULL1, main ← in.
  - FULL1:
    - in_fire & out_fire → FULL1, main ← in.
    - in_fire only → FULL2, skid ← in.
    - out_fire only → EMPTY.
  - FULL2:
    - in_ready = 0.
    - out_fire → FULL1, main ← skid.
- `out_valid` = state ≠ EMPTY. `out_data` = main entry.
- `flush` → EMPTY next cycle, overriding any same-cycle in_fire; data registers are kept.
- `stall_cnt` increments by 1 per stalled cycle, holds at all-ones, and is not cleared by flush.

## Timing
- Reset values:
  - state EMPTY, `out_valid` 0, `out_data` 0, `stall_cnt` 0.
  - `in_ready` 0 during the reset cycle, 1 on the first cycle after it.
- Latency: in_fire at cycle N → `out_valid`=1 with that data at N+1.
- Throughput: 1 per cycle while `out_ready`=1.
- `in_ready` (skid build) is a flop equal to !FULL2; it is never combinationally dependent on `out_ready`.
- `out_data` is stable while `out_valid & !out_ready`.
- Reset mid-transfer discards both entries, with no output beat.

## Configuration
- `PIPE_REG_SKID_EN` defined:
  - Two-entry stage as above.
  - `in_ready` registered; full rate under single-cycle stalls.
- Not defined:
  - Single entry only, no FULL2 state.
  - `in_ready` = !out_valid | out_ready, combinational.
  - Same latency, layout, flush, and counter behaviour.

## Test plan
- Layout: inst=0x8C220004, A=0x11111111, B=0x22222222, PC=0xBFC00000, aluop=0x0001, regfile_waddr=2, others 0, `out_ready`=1 → `out_data`[200:169]=0x8C220004, [104:73]=0xBFC00000, [4:0]=2, [219:201]=0, one cycle after in_fire.
- Streaming: 8 back-to-back beats with `out_ready`=1 → 8 output beats in order, no bubbles, `stall_cnt`=0.
- Skid: `out_ready`=0 after beat 1, `in_valid` held → beat 2 lands in skid, `in_ready`=0 next cycle; then `out_ready`=1 → beats 1 and 2 on consecutive cycles (skid build).
- Flush: flush with FULL2 and a simultaneous in_fire → `out_valid`=0 next cycle, no beat delivered, `in_ready`=1.
- Counter: force `out_ready`=0 for 5 cycles with `out_valid`=1 → `stall_cnt`=5; with STALL_CNT_W=4 and 20 stall cycles → 15.
- Reset: assert `rst` while FULL1 → next cycle `out_valid`=0, `out_data`=0, `stall_cnt`=0.
